// File: rtl/seq_detector_param.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : seq_detector_param                                         |
// | Description : Serial bit-pattern detector with a runtime-loadable        |
// |               pattern/length, overlapping or non-overlapping matching,   |
// |               input qualifier and a saturating match counter.            |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module seq_detector_param #(
  parameter int                 MAX_LEN = 8,
  parameter int                 LEN_W   = 4,
  parameter logic [MAX_LEN-1:0] DEF_PAT = MAX_LEN'(8'h07),
  parameter int                 DEF_LEN = 3,
  parameter int                 CNT_W   = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               din,
  input  logic               din_valid,
  input  logic               cfg_load,
  input  logic [MAX_LEN-1:0] pat,
  input  logic [LEN_W-1:0]   pat_len,
  input  logic               overlap,
  input  logic               cnt_clr,
  output logic               dout,
  output logic [CNT_W-1:0]   match_cnt,
  output logic               cfg_err
);

  localparam logic [LEN_W:0]   c_MAX_LEN_EXT = (LEN_W+1)'(MAX_LEN);
  localparam logic [LEN_W:0]   c_ONE_EXT     = (LEN_W+1)'(1);
  localparam logic [LEN_W-1:0] c_FILL_FULL   = LEN_W'(MAX_LEN);
  localparam logic [LEN_W-1:0] c_FILL_ONE    = LEN_W'(1);
  localparam logic [LEN_W-1:0] c_DEF_LEN     = LEN_W'(DEF_LEN);
  localparam logic [CNT_W-1:0] c_CNT_MAX     = '1;
  localparam logic [CNT_W-1:0] c_CNT_ONE     = CNT_W'(1);

  // Active configuration and history state
  logic [MAX_LEN-1:0] r_pat;
  logic [LEN_W-1:0]   r_len;
  logic               r_overlap;
  logic               r_cfg_err;
  logic [MAX_LEN-1:0] r_hist;
  logic [LEN_W-1:0]   r_fill;
  logic               r_dout;
  logic [CNT_W-1:0]   r_cnt;

  logic [MAX_LEN-1:0] w_shift;
  logic [MAX_LEN-1:0] w_mask;
  logic               w_valid;
  logic               w_enough;
  logic               w_hit;
  logic               w_len_bad;

  // A bit is only consumed when qualified, not overridden by a config load,
  // and the active configuration is legal.
  assign w_valid   = din_valid && !cfg_load && !r_cfg_err;
  assign w_shift   = {r_hist[MAX_LEN-2:0], din};
  assign w_enough  = ({1'b0, r_fill} + c_ONE_EXT) >= {1'b0, r_len};
  assign w_hit     = w_valid && w_enough && ((w_shift & w_mask) == (r_pat & w_mask));
  assign w_len_bad = (pat_len == '0) || ({1'b0, pat_len} > c_MAX_LEN_EXT);

  // Build a mask selecting the low r_len bits of the history window
  always_comb begin
    w_mask = '0;
    for (int i = 0; i < MAX_LEN; i++) begin
      w_mask[i] = (LEN_W'(i) < r_len);
    end
  end

  // Configuration latch plus history/fill tracking; a non-overlapping hit
  // empties the fill count so the next match needs a full fresh pattern.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_pat     <= DEF_PAT;
      r_len     <= c_DEF_LEN;
      r_overlap <= 1'b0;
      r_cfg_err <= 1'b0;
      r_hist    <= '0;
      r_fill    <= '0;
    end else if (cfg_load) begin
      r_pat     <= pat;
      r_len     <= pat_len;
      r_overlap <= overlap;
      r_cfg_err <= w_len_bad;
      r_hist    <= '0;
      r_fill    <= '0;
    end else if (w_valid) begin
      r_hist <= w_shift;
      if (w_hit && !r_overlap) begin
        r_fill <= '0;
      end else if (r_fill != c_FILL_FULL) begin
        r_fill <= r_fill + c_FILL_ONE;
      end
    end
  end

  // Registered one-cycle match pulse
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_dout <= 1'b0;
    end else begin
      r_dout <= w_hit;
    end
  end

  // Saturating match counter; a clear takes precedence over a same-cycle hit
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if (cnt_clr) begin
      r_cnt <= '0;
    end else if (w_hit && (r_cnt != c_CNT_MAX)) begin
      r_cnt <= r_cnt + c_CNT_ONE;
    end
  end

  assign dout      = r_dout;
  assign match_cnt = r_cnt;
  assign cfg_err   = r_cfg_err;

endmodule
`default_nettype wire

// File: tb/tb_seq_detector_param.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_seq_detector_param                                      |
// | Description : Self-checking bench for seq_detector_param; a wide-counter |
// |               and a 2-bit-counter instance share one stimulus stream and |
// |               are checked against a queue-based reference model.         |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_seq_detector_param;

  localparam int MAX_LEN = 8;
  localparam int LEN_W   = 4;

  logic               clk = 1'b0;
  logic               rst;
  logic               din;
  logic               din_valid;
  logic               cfg_load;
  logic [MAX_LEN-1:0] pat;
  logic [LEN_W-1:0]   pat_len;
  logic               overlap;
  logic               cnt_clr;
  logic               dout,  dout2;
  logic [7:0]         match_cnt;
  logic [1:0]         match_cnt2;
  logic               cfg_err, cfg_err2;

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model: the bits received since the last reset/config load or
  // non-overlapping match, newest at the back.
  bit         m_q[$];
  bit [7:0]   m_pat;
  int         m_len;
  bit         m_ov;
  bit         m_err;
  int         m_cnt;
  bit         m_dout;

  always #5 clk = ~clk;

  seq_detector_param #(.MAX_LEN(8), .LEN_W(4), .DEF_PAT(8'h07), .DEF_LEN(3), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .cfg_load(cfg_load),
    .pat(pat), .pat_len(pat_len), .overlap(overlap), .cnt_clr(cnt_clr),
    .dout(dout), .match_cnt(match_cnt), .cfg_err(cfg_err)
  );

  seq_detector_param #(.MAX_LEN(8), .LEN_W(4), .DEF_PAT(8'h07), .DEF_LEN(3), .CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .cfg_load(cfg_load),
    .pat(pat), .pat_len(pat_len), .overlap(overlap), .cnt_clr(cnt_clr),
    .dout(dout2), .match_cnt(match_cnt2), .cfg_err(cfg_err2)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    m_q.delete();
    m_pat  = 8'h07;
    m_len  = 3;
    m_ov   = 1'b0;
    m_err  = 1'b0;
    m_cnt  = 0;
    m_dout = 1'b0;
  endfunction

  // Apply one cycle of inputs, advance the model, then check both DUTs.
  task automatic step(input bit r, input bit d, input bit v, input bit ld,
                      input bit [7:0] p, input int len, input bit ov, input bit clr);
    bit hit;
    rst = r; din = d; din_valid = v; cfg_load = ld;
    pat = p; pat_len = LEN_W'(len); overlap = ov; cnt_clr = clr;
    hit = 1'b0;
    if (!r) begin
      model_reset();
    end else begin
      if (ld) begin
        m_pat = p; m_len = len; m_ov = ov;
        m_err = (len == 0) || (len > MAX_LEN);
        m_q.delete();
      end else if (v && !m_err) begin
        m_q.push_back(d);
        if (m_q.size() > MAX_LEN) void'(m_q.pop_front());
        if (m_q.size() >= m_len) begin
          hit = 1'b1;
          for (int k = 0; k < m_len; k++)
            if (m_q[m_q.size()-1-k] != m_pat[k]) hit = 1'b0;
        end
        if (hit && !m_ov) m_q.delete();
      end
      m_dout = hit;
      if (clr) m_cnt = 0;
      else if (hit) m_cnt++;
    end
    @(posedge clk);
    #1;
    chk("dout",       dout,       m_dout);
    chk("match_cnt",  match_cnt,  (m_cnt > 255) ? 255 : m_cnt);
    chk("cfg_err",    cfg_err,    m_err);
    chk("dout2",      dout2,      m_dout);
    chk("match_cnt2", match_cnt2, (m_cnt > 3) ? 3 : m_cnt);
  endtask

  task automatic bitv(input bit d, input bit v);
    step(1'b1, d, v, 1'b0, 8'h00, 0, 1'b0, 1'b0);
  endtask

  task automatic load(input bit [7:0] p, input int len, input bit ov);
    step(1'b1, 1'b0, 1'b0, 1'b1, p, len, ov, 1'b0);
  endtask

  task automatic clear();
    step(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 0, 1'b0, 1'b1);
  endtask

  initial begin
    bit [6:0] s;
    model_reset();
    // Reset state
    step(1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 0, 1'b0, 1'b0);
    chk("reset_dout", dout, 0);
    chk("reset_cnt", match_cnt, 0);

    // Default "111", non-overlapping: six ones give two matches
    for (int i = 0; i < 6; i++) bitv(1'b1, 1'b1);
    chk("default_cnt", match_cnt, 2);

    // 1011 overlapping over 1,0,1,1,0,1,1
    clear();
    load(8'b1011, 4, 1'b1);
    s = 7'b1011011;
    for (int i = 6; i >= 0; i--) bitv(s[i], 1'b1);
    chk("ovl_cnt", match_cnt, 2);

    // Same stream, non-overlapping
    clear();
    load(8'b1011, 4, 1'b0);
    for (int i = 6; i >= 0; i--) bitv(s[i], 1'b1);
    chk("novl_cnt", match_cnt, 1);

    // Gaps in din_valid do not break a partial match
    clear();
    load(8'b1011, 4, 1'b0);
    bitv(1'b1, 1'b1); bitv(1'b0, 1'b1);
    for (int i = 0; i < 3; i++) bitv(1'b1, 1'b0);
    bitv(1'b1, 1'b1); bitv(1'b1, 1'b1);
    chk("gap_dout", dout, 1);

    // Saturation of the 2-bit counter, then clear coinciding with a hit
    clear();
    load(8'b1, 1, 1'b1);
    for (int i = 0; i < 5; i++) bitv(1'b1, 1'b1);
    chk("sat_cnt2", match_cnt2, 3);
    step(1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 0, 1'b0, 1'b1);
    chk("clr_hit_dout", dout, 1);
    chk("clr_hit_cnt", match_cnt, 0);

    // Illegal lengths block all matching
    load(8'hFF, 0, 1'b1);
    for (int i = 0; i < 6; i++) bitv(1'b1, 1'b1);
    chk("len0_cnt", match_cnt, 0);
    load(8'hFF, 9, 1'b1);
    for (int i = 0; i < 10; i++) bitv(1'b1, 1'b1);
    chk("len9_err", cfg_err, 1);

    // Full-length pattern, then reset mid-pattern restores defaults
    load(8'b10110010, 8, 1'b0);
    s = 7'b1011001;
    for (int i = 6; i >= 0; i--) bitv(s[i], 1'b1);
    bitv(1'b0, 1'b1);
    chk("len8_dout", dout, 1);
    bitv(1'b1, 1'b1); bitv(1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 0, 1'b0, 1'b0);
    chk("rst_dout", dout, 0);
    for (int i = 0; i < 3; i++) bitv(1'b1, 1'b1);
    chk("rst_def_dout", dout, 1);

    // Randomised traffic with occasional reconfiguration, clears and resets
    for (int n = 0; n < 3000; n++) begin
      int r;
      r = $urandom_range(0, 199);
      if (r == 0)
        step(1'b0, 1'($urandom), 1'b1, 1'b0, 8'h00, 0, 1'b0, 1'b0);
      else if (r < 5)
        load(8'($urandom), $urandom_range(0, 9), 1'($urandom));
      else
        step(1'b1, 1'($urandom), ($urandom_range(0, 3) != 0), 1'b0, 8'h00, 0,
             1'b0, ($urandom_range(0, 39) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
